// File: rtl/multdiv_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : multdiv_ctrl
// Brief    : Execute-stage sequencer for the multi-cycle multiply/divide unit.
//            Stalls the front end, starts the unit, waits (with a watchdog)
//            and overrides the X->M result, mapping faults to rstatus writes.
// Revision : 1.0 - initial release
// ============================================================================
module multdiv_ctrl #(
    parameter int TIMEOUT     = 40,
    parameter int MUL_CODE    = 4,
    parameter int DIV_CODE    = 5,
    parameter int RSTATUS_REG = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        x_valid,
    input  logic [4:0]  x_opcode,
    input  logic [4:0]  x_aluop,
    input  logic [4:0]  x_rd,
    input  logic [31:0] x_opA,
    input  logic [31:0] x_opB,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        stall,
    output logic        res_valid,
    output logic        res_wren,
    output logic [4:0]  res_rd,
    output logic [31:0] res_data,
    output logic        timeout,
    output logic        busy
);

    localparam int         c_CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [4:0] c_OPCODE_ALU = 5'd0;
    localparam logic [4:0] c_ALU_MUL    = 5'd6;
    localparam logic [4:0] c_ALU_DIV    = 5'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_is_div;
    logic [4:0]           r_rd;
    logic [31:0]          r_opa;
    logic [31:0]          r_opb;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_mult;
    logic                 r_div;
    logic                 r_res_valid;
    logic                 r_res_wren;
    logic                 r_timeout;
    logic [4:0]           r_res_rd;
    logic [31:0]          r_res_data;

    logic                 w_detect;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic                 w_cnt_expired;
    logic                 w_finish;
    logic                 w_fin_exc;
    logic                 w_fin_to;
    logic [4:0]           w_fin_rd;
    logic [31:0]          w_fin_data;

    assign w_detect = x_valid && (x_opcode == c_OPCODE_ALU) &&
                      ((x_aluop == c_ALU_MUL) || (x_aluop == c_ALU_DIV));

    assign w_cnt_next    = r_cnt + c_CNT_W'(1);
    assign w_cnt_expired = (w_cnt_next == c_CNT_W'(TIMEOUT));
    assign w_finish      = md_resultRDY || w_cnt_expired;

    // A ready result always beats a watchdog expiring in the same cycle.
    assign w_fin_to   = !md_resultRDY;
    assign w_fin_exc  = md_resultRDY ? md_exception : 1'b1;
    assign w_fin_rd   = w_fin_exc ? 5'(RSTATUS_REG) : r_rd;
    assign w_fin_data = w_fin_exc ? (r_is_div ? 32'(DIV_CODE) : 32'(MUL_CODE))
                                  : md_result;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_is_div    <= 1'b0;
            r_rd        <= 5'd0;
            r_opa       <= 32'd0;
            r_opb       <= 32'd0;
            r_cnt       <= '0;
            r_mult      <= 1'b0;
            r_div       <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_wren  <= 1'b0;
            r_timeout   <= 1'b0;
            r_res_rd    <= 5'd0;
            r_res_data  <= 32'd0;
        end else begin
            r_mult      <= 1'b0;
            r_div       <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_wren  <= 1'b0;
            r_timeout   <= 1'b0;
            r_res_rd    <= 5'd0;
            r_res_data  <= 32'd0;
            case (r_state)
                S_IDLE: begin
                    if (w_detect) begin
                        r_opa    <= x_opA;
                        r_opb    <= x_opB;
                        r_rd     <= x_rd;
                        r_is_div <= (x_aluop == c_ALU_DIV);
                        r_mult   <= (x_aluop == c_ALU_MUL);
                        r_div    <= (x_aluop == c_ALU_DIV);
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= w_cnt_next;
                    if (w_finish) begin
                        r_res_valid <= 1'b1;
                        r_res_rd    <= w_fin_rd;
                        r_res_data  <= w_fin_data;
                        r_res_wren  <= (w_fin_rd != 5'd0);
                        r_timeout   <= w_fin_to;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stall = ((r_state == S_IDLE) && w_detect) ||
                   (r_state == S_START) || (r_state == S_WAIT);
    assign busy  = (r_state != S_IDLE);

    assign md_ctrl_mult = r_mult;
    assign md_ctrl_div  = r_div;
    assign md_operandA  = r_opa;
    assign md_operandB  = r_opb;
    assign res_valid    = r_res_valid;
    assign res_wren     = r_res_wren;
    assign res_rd       = r_res_rd;
    assign res_data     = r_res_data;
    assign timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_multdiv_ctrl
// Brief    : Self-checking bench for multdiv_ctrl: cycle-indexed reference
//            model plus directed and randomized mul/div traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv_ctrl;

    localparam int TIMEOUT     = 40;
    localparam int MUL_CODE    = 4;
    localparam int DIV_CODE    = 5;
    localparam int RSTATUS_REG = 30;

    logic        clock = 1'b0;
    logic        reset;
    logic        x_valid;
    logic [4:0]  x_opcode;
    logic [4:0]  x_aluop;
    logic [4:0]  x_rd;
    logic [31:0] x_opA;
    logic [31:0] x_opB;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;
    logic        stall;
    logic        res_valid;
    logic        res_wren;
    logic [4:0]  res_rd;
    logic [31:0] res_data;
    logic        timeout;
    logic        busy;

    always #5 clock = ~clock;

    multdiv_ctrl #(
        .TIMEOUT     (TIMEOUT),
        .MUL_CODE    (MUL_CODE),
        .DIV_CODE    (DIV_CODE),
        .RSTATUS_REG (RSTATUS_REG)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .x_valid      (x_valid),
        .x_opcode     (x_opcode),
        .x_aluop      (x_aluop),
        .x_rd         (x_rd),
        .x_opA        (x_opA),
        .x_opB        (x_opB),
        .md_ctrl_mult (md_ctrl_mult),
        .md_ctrl_div  (md_ctrl_div),
        .md_operandA  (md_operandA),
        .md_operandB  (md_operandB),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_resultRDY (md_resultRDY),
        .stall        (stall),
        .res_valid    (res_valid),
        .res_wren     (res_wren),
        .res_rd       (res_rd),
        .res_data     (res_data),
        .timeout      (timeout),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the op by its cycle index since detection.
    bit          m_active = 1'b0;
    int          m_t;
    int          m_done_t;
    bit          m_div;
    logic [4:0]  m_rd;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [31:0] m_res;
    bit          m_exc;
    bit          m_to;

    always @(negedge clock) begin
        bit          det;
        logic [4:0]  erd;
        logic [31:0] edata;
        det = x_valid && (x_opcode == 5'd0) && ((x_aluop == 5'd6) || (x_aluop == 5'd7));
        if (reset) begin
            chk("rst_stall", stall, det);
            chk("rst_busy", busy, 0);
            chk("rst_mult", md_ctrl_mult, 0);
            chk("rst_div", md_ctrl_div, 0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_res_wren", res_wren, 0);
            chk("rst_timeout", timeout, 0);
            chk("rst_opA", md_operandA, 0);
            chk("rst_opB", md_operandB, 0);
            m_active = 1'b0;
        end else if (!m_active) begin
            chk("idle_stall", stall, det);
            chk("idle_busy", busy, 0);
            chk("idle_mult", md_ctrl_mult, 0);
            chk("idle_div", md_ctrl_div, 0);
            chk("idle_res_valid", res_valid, 0);
            chk("idle_res_wren", res_wren, 0);
            chk("idle_timeout", timeout, 0);
            if (det) begin
                m_active = 1'b1;
                m_t      = 1;
                m_done_t = -1;
                m_div    = (x_aluop == 5'd7);
                m_rd     = x_rd;
                m_a      = x_opA;
                m_b      = x_opB;
                m_exc    = 1'b0;
                m_to     = 1'b0;
            end
        end else if (m_t == m_done_t) begin
            erd   = m_exc ? 5'(RSTATUS_REG) : m_rd;
            edata = m_exc ? (m_div ? 32'(DIV_CODE) : 32'(MUL_CODE)) : m_res;
            chk("done_stall", stall, 0);
            chk("done_busy", busy, 1);
            chk("done_mult", md_ctrl_mult, 0);
            chk("done_div", md_ctrl_div, 0);
            chk("done_res_valid", res_valid, 1);
            chk("done_res_rd", res_rd, erd);
            chk("done_res_data", res_data, edata);
            chk("done_res_wren", res_wren, erd != 5'd0);
            chk("done_timeout", timeout, m_to);
            chk("done_opA", md_operandA, m_a);
            chk("done_opB", md_operandB, m_b);
            m_active = 1'b0;
        end else begin
            chk("run_stall", stall, 1);
            chk("run_busy", busy, 1);
            chk("run_mult", md_ctrl_mult, (m_t == 1) && !m_div);
            chk("run_div", md_ctrl_div, (m_t == 1) && m_div);
            chk("run_res_valid", res_valid, 0);
            chk("run_res_wren", res_wren, 0);
            chk("run_timeout", timeout, 0);
            chk("run_opA", md_operandA, m_a);
            chk("run_opB", md_operandB, m_b);
            if (m_t >= 2 && md_resultRDY) begin
                m_done_t = m_t + 1;
                m_res    = md_result;
                m_exc    = md_exception;
                m_to     = 1'b0;
            end else if (m_t == TIMEOUT + 1) begin
                m_done_t = m_t + 1;
                m_exc    = 1'b1;
                m_to     = 1'b1;
            end
            m_t++;
        end
    end

    // Observations from the most recent run_op / run_fill call.
    int          obs_done, obs_stall_cnt, obs_mul_cnt, obs_div_cnt, obs_mul_cyc;
    bit          obs_stall0;
    logic [4:0]  obs_rd;
    logic [31:0] obs_data;
    bit          obs_wren, obs_to;
    bit          obs_rst_busy, obs_rst_stall, obs_rst_rv, obs_late_busy, obs_late_rv;
    bit          obs_fill_stall, obs_fill_busy;

    // Presents one mul/div in X and plays the multdiv unit; lat = cycles from
    // START to the sampled RDY (0 = never), reset_at < 0 = no reset.
    task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int lat, input bit exc,
                          input logic [31:0] result, input int reset_at);
        int  done;
        bit  rdy_now;
        done = (lat >= 1 && lat <= TIMEOUT) ? 2 + lat : 2 + TIMEOUT;
        obs_done = -1; obs_stall_cnt = 0; obs_mul_cnt = 0; obs_div_cnt = 0;
        obs_mul_cyc = -1; obs_stall0 = 1'b0;
        for (int cyc = 0; cyc <= done; cyc++) begin
            @(posedge clock); #1;
            if (cyc == reset_at) begin
                x_valid = 1'b0; md_resultRDY = 1'b0; reset = 1'b1;
                @(negedge clock);
                obs_rst_busy = busy; obs_rst_stall = stall; obs_rst_rv = res_valid;
                @(posedge clock); #1;
                @(posedge clock); #1;
                reset = 1'b0; md_resultRDY = 1'b1; md_result = $urandom; md_exception = 1'b1;
                @(negedge clock);
                obs_late_busy = busy; obs_late_rv = res_valid;
                return;
            end
            x_valid  = 1'b1;
            x_opcode = 5'd0;
            x_aluop  = is_div ? 5'd7 : 5'd6;
            x_rd     = rd;
            x_opA    = (cyc == 0) ? a : $urandom;
            x_opB    = (cyc == 0) ? b : $urandom;
            rdy_now  = (lat >= 1) && (cyc == 1 + lat);
            md_resultRDY = rdy_now || (cyc <= 1 && $urandom_range(0, 3) == 0);
            md_result    = rdy_now ? result : $urandom;
            md_exception = rdy_now ? exc : 1'($urandom_range(0, 1));
            @(negedge clock);
            if (cyc == 0) obs_stall0 = stall;
            if (stall) obs_stall_cnt++;
            if (md_ctrl_mult) begin obs_mul_cnt++; obs_mul_cyc = cyc; end
            if (md_ctrl_div) obs_div_cnt++;
            if (res_valid) begin
                obs_done = cyc; obs_rd = res_rd; obs_data = res_data;
                obs_wren = res_wren; obs_to = timeout;
            end
        end
    endtask

    task automatic run_fill(input bit v, input logic [4:0] opc, input logic [4:0] alu, input bit rdy);
        @(posedge clock); #1;
        x_valid = v; x_opcode = opc; x_aluop = alu; x_rd = 5'($urandom);
        x_opA = $urandom; x_opB = $urandom;
        md_resultRDY = rdy; md_result = $urandom; md_exception = 1'($urandom_range(0, 1));
        @(negedge clock);
        obs_fill_stall = stall; obs_fill_busy = busy;
    endtask

    task automatic random_fill();
        bit         v;
        logic [4:0] opc, alu;
        v   = 1'($urandom_range(0, 1));
        opc = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
        alu = 5'($urandom_range(0, 7));
        if (v && opc == 5'd0 && (alu == 5'd6 || alu == 5'd7)) alu = 5'd0;
        run_fill(v, opc, alu, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        reset = 1'b1; x_valid = 1'b0; x_opcode = 5'd0; x_aluop = 5'd0; x_rd = 5'd0;
        x_opA = 32'd0; x_opB = 32'd0; md_result = 32'd0; md_exception = 1'b0;
        md_resultRDY = 1'b0;
        repeat (3) @(negedge clock);
        chk("por_busy", busy, 0);
        chk("por_stall", stall, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        // mul 7*6 -> rd3, RDY sampled 32 cycles after START
        run_op(1'b0, 32'd7, 32'd6, 5'd3, 32, 1'b0, 32'd42, -1);
        chk("mul_done_cycle", obs_done, 34);
        chk("mul_stall_cycles", obs_stall_cnt, 34);
        chk("mul_stall_c0", obs_stall0, 1);
        chk("mul_pulse_cnt", obs_mul_cnt, 1);
        chk("mul_pulse_cycle", obs_mul_cyc, 1);
        chk("mul_res_rd", obs_rd, 3);
        chk("mul_res_data", obs_data, 42);
        chk("mul_res_wren", obs_wren, 1);

        run_fill(1'b0, 5'd0, 5'd0, 1'b0);
        run_op(1'b1, 32'd100, 32'd0, 5'd9, 5, 1'b1, 32'hDEAD_BEEF, -1);
        chk("div0_rd", obs_rd, 30);
        chk("div0_data", obs_data, 5);
        chk("div0_pulse", obs_div_cnt, 1);
        chk("div0_no_mul", obs_mul_cnt, 0);

        run_op(1'b0, 32'h8000_0000, 32'd4, 5'd11, 3, 1'b1, 32'd0, -1);
        chk("mulovf_rd", obs_rd, 30);
        chk("mulovf_data", obs_data, 4);

        run_op(1'b0, 32'd3, 32'd3, 5'd12, 0, 1'b0, 32'd0, -1);
        chk("wdog_done_cycle", obs_done, 42);
        chk("wdog_timeout", obs_to, 1);
        chk("wdog_rd", obs_rd, 30);
        chk("wdog_data", obs_data, 4);

        run_op(1'b0, 32'd5, 32'd5, 5'd13, TIMEOUT, 1'b0, 32'd25, -1);
        chk("tie_done_cycle", obs_done, 42);
        chk("tie_timeout", obs_to, 0);
        chk("tie_rd", obs_rd, 13);
        chk("tie_data", obs_data, 25);

        run_op(1'b1, 32'd9, 32'd3, 5'd14, TIMEOUT + 1, 1'b0, 32'd3, -1);
        chk("late_rdy_timeout", obs_to, 1);
        chk("late_rdy_data", obs_data, 5);

        // back-to-back
        run_op(1'b0, 32'd2, 32'd8, 5'd5, 4, 1'b0, 32'd16, -1);
        chk("b2b1_rd", obs_rd, 5);
        chk("b2b1_data", obs_data, 16);
        run_op(1'b1, 32'd50, 32'd7, 5'd6, 9, 1'b0, 32'd7, -1);
        chk("b2b2_detect", obs_stall0, 1);
        chk("b2b2_div_pulse", obs_div_cnt, 1);
        chk("b2b2_rd", obs_rd, 6);
        chk("b2b2_data", obs_data, 7);

        run_op(1'b0, 32'd4, 32'd4, 5'd0, 2, 1'b0, 32'd16, -1);
        chk("rd0_done_cycle", obs_done, 4);
        chk("rd0_wren", obs_wren, 0);

        run_fill(1'b1, 5'd0, 5'd0, 1'b0);
        chk("add_stall", obs_fill_stall, 0);
        run_fill(1'b1, 5'd5, 5'd6, 1'b1);
        chk("addi_stall", obs_fill_stall, 0);
        chk("addi_busy", obs_fill_busy, 0);
        run_fill(1'b0, 5'd0, 5'd6, 1'b0);
        chk("bubble_stall", obs_fill_stall, 0);
        chk("bubble_busy", obs_fill_busy, 0);

        run_op(1'b0, 32'd10, 32'd10, 5'd7, 20, 1'b0, 32'd100, 10);
        chk("rst_mid_busy", obs_rst_busy, 0);
        chk("rst_mid_stall", obs_rst_stall, 0);
        chk("rst_mid_rv", obs_rst_rv, 0);
        chk("rst_late_rv", obs_late_rv, 0);
        chk("rst_late_busy", obs_late_busy, 0);
        run_op(1'b0, 32'd11, 32'd3, 5'd8, 6, 1'b0, 32'd33, -1);
        chk("post_rst_rd", obs_rd, 8);
        chk("post_rst_data", obs_data, 33);

        for (int i = 0; i < 150; i++) begin
            int          sel, lat, rst_at;
            bit          dv;
            logic [31:0] a, b;
            repeat ($urandom_range(0, 2)) random_fill();
            dv  = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            sel = $urandom_range(0, 9);
            lat = (sel == 0) ? 0 : (sel == 1) ? TIMEOUT : (sel == 2) ? TIMEOUT + 1
                                                         : $urandom_range(1, 12);
            rst_at = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 14) : -1;
            run_op(dv, a, b, 5'($urandom), lat, ($urandom_range(0, 3) == 0),
                   $urandom, rst_at);
            if (rst_at >= 0) begin
                chk("rnd_rst_busy", obs_rst_busy, 0);
                chk("rnd_rst_rv", obs_rst_rv, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Execute-stage sequencer for the multi-cycle multiply/divide unit. It detects a `mul`/`div` in X, freezes the front of the pipeline, and issues a one-cycle start pulse to the multdiv unit with latched operands. It then waits for result-ready, with a watchdog timeout, and substitutes the result into the X→M path on release. Exceptions are converted into the rstatus (`$r30`) write the rest of the pipeline expects.

## Interface
Parameters:
- `TIMEOUT`, 40: max WAIT cycles before forced completion (≥ 2).
- `MUL_CODE`, 4: rstatus value for a `mul` exception or timeout.
- `DIV_CODE`, 5: rstatus value for a `div` exception or timeout.
- `RSTATUS_REG`, 30: destination register for exception writes.

Ports:
- `clock`  in  1  rising-edge clock; single clock domain.
- `reset`  in  1  asynchronous, active-high.
- `x_valid`  in  1  X stage holds a real instruction (not a bubble).
- `x_opcode`  in  5  X-stage opcode.
- `x_aluop`  in  5  X-stage ALU op field.
- `x_rd`  in  5  X-stage destination register.
- `x_opA`, `x_opB`  in  32  bypassed X-stage operands.
- `md_ctrl_mult`, `md_ctrl_div`  out  1  one-cycle start pulses to the multdiv unit.
- `md_operandA`, `md_operandB`  out  32  latched operands, stable from START through DONE.
- `md_result`  in  32  multdiv result.
- `md_exception`  in  1  overflow or divide-by-zero, valid with `md_resultRDY`.
- `md_resultRDY`  in  1  result-ready from the multdiv unit.
- `stall`  out  1  freeze PC, F/D and D/X latches; hold X.
- `res_valid`  out  1  override the X-stage result this cycle.
- `res_wren`  out  1  register write enable for the overridden result.
- `res_rd`  out  5  destination register for the overridden result.
- `res_data`  out  32  data for the overridden result.
- `timeout`  out  1  one-cycle pulse in DONE when completion was forced by the watchdog.
- `busy`  out  1  state ≠ IDLE.

## Operation
- The block detects a mul/div op when `x_valid` is high, `x_opcode == 0`, and `x_aluop` is 6 (mul) or 7 (div). A nonzero opcode (e.g. `addi` carrying 6 in the aluop bits) never triggers.
- State machine: IDLE, START, WAIT, DONE.
  - IDLE: on detect, latch the operands, `x_rd` and the op kind, then go to START. `stall` is driven combinationally high in the detect cycle.
  - START: pulse `md_ctrl_mult` or `md_ctrl_div` according to the latched op. Clear the counter and go to WAIT.
  - WAIT: increment the counter each cycle. If `md_resultRDY` is high, latch `md_result` and `md_exception` and go to DONE. Else, if the counter reaches `TIMEOUT`, set the exception and timeout flags and go to DONE.
  - DONE: `stall` = 0 and `res_valid` = 1 for exactly one cycle, so the mul/div leaves X carrying the override. Always go to IDLE next; there is no re-detection in DONE.
- Result selection in DONE:
  - No exception: `res_rd` = latched rd, `res_data` = latched result.
  - Exception or timeout: `res_rd` = `RSTATUS_REG`, `res_data` = `MUL_CODE` or `DIV_CODE`, zero-extended to 32 bits.
  - `res_wren` = `res_valid` AND (`res_rd` ≠ 0).
- `md_resultRDY` outside WAIT is ignored.
- Counter width is clog2(`TIMEOUT`+1). If `md_resultRDY` and the timeout land in the same cycle, RDY wins: normal completion, no timeout pulse.
- `stall` = detect-in-IDLE OR state ∈ {START, WAIT}.

## Timing
- Reset, asserted at any time including mid-WAIT:
  - state goes to IDLE immediately; all outputs go to 0 (`stall` still follows the combinational detect).
  - latched regs go to 0.
  - no start pulse is issued; the multdiv unit is reset separately.
- Cycle numbering, with the detect at cycle 0:
  - START at cycle 1, the only cycle with a `md_ctrl_*` pulse.
  - WAIT from cycle 2 onward.
  - If RDY is sampled at cycle k, DONE is at cycle k+1 and `stall` is low only at k+1.
  - Total stall cycles = k+1.
- Worst case (timeout): DONE at cycle 2+`TIMEOUT`.
- Back-to-back mul/div: the second op enters X in the cycle after DONE and is detected in IDLE that cycle. There are no dead cycles between ops.
- `md_operandA` and `md_operandB` hold their value across START and WAIT even if X-stage operands change.

## Test plan
- `mul`, A=7, B=6, rd=3, RDY sampled 32 cycles after START: `stall` high for cycles 0–33; `md_ctrl_mult` high only at cycle 1; cycle 34 has `res_valid`=1, `res_rd`=3, `res_data`=42, `res_wren`=1.
- `div`, A=100, B=0, with `md_exception`=1 on RDY: DONE gives `res_rd`=30 and `res_data`=5. `mul` overflow with the exception gives `res_rd`=30 and `res_data`=4.
- Watchdog: `mul` with RDY never asserted: DONE at cycle 42 (`TIMEOUT`=40) with `timeout`=1, `res_rd`=30, `res_data`=4. RDY and the timeout in the same cycle give a normal result and `timeout`=0.
- Back-to-back `mul` rd=5 then `div` rd=6: the second detect occurs the cycle after the first DONE; exactly one `md_ctrl_div` pulse; both results are overridden in order. A `mul` with rd=0 gives `res_valid`=1 and `res_wren`=0.
- Non-triggers: add (aluop 0), `addi` (opcode 5, aluop bits 6), and `x_valid`=0 with aluop 6 all keep `stall`=0 and `busy`=0.
- Reset asserted asynchronously mid-WAIT: same cycle `busy`=0, `stall`=0, `res_valid`=0. A late RDY is ignored, and a new `mul` after reset completes normally.
